// File: rtl/lc3_pipeline_controller_if.sv
// rtl/lc3_pipeline_controller_if.sv - stage-enable and status bundle between LC-3 controller and datapath
interface lc3_pipeline_controller_if;
    logic [15:0] instr_dout;
    logic [15:0] ir_exec;
    logic [2:0]  psr;
    logic        complete_data;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_update_pc;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        mem_timeout;

    modport master (
        input  instr_dout, ir_exec, psr, complete_data,
        output enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_update_pc, br_taken, mem_state, mem_timeout
    );

    modport slave (
        output instr_dout, ir_exec, psr, complete_data,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback,
               enable_update_pc, br_taken, mem_state, mem_timeout
    );
endinterface

// File: rtl/lc3_pipeline_controller.sv
// rtl/lc3_pipeline_controller.sv - LC-3 five-stage pipeline sequencer: fill, memory stalls, branch bubbles
module lc3_pipeline_controller #(
    parameter int FILL_DEPTH  = 4,
    parameter int BR_BUBBLES  = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input logic                       clk,
    input logic                       rst,
    lc3_pipeline_controller_if.master ctrl_io
);
    localparam int FW = $clog2(FILL_DEPTH + 1);
    localparam int BW = $clog2(BR_BUBBLES + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_DEPTH - 1);
    localparam logic [FW-1:0] FILL_DEC  = FW'(1);
    localparam logic [FW-1:0] FILL_EXE  = FW'(2);
    localparam logic [FW-1:0] FILL_WB   = FW'(3);
    localparam logic [BW-1:0] BUB_LAST  = BW'(BR_BUBBLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam logic [1:0] MS_READ  = 2'b00;
    localparam logic [1:0] MS_IND   = 2'b01;
    localparam logic [1:0] MS_WRITE = 2'b10;
    localparam logic [1:0] MS_IDLE  = 2'b11;

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_MEM, ST_CTRL} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [BW-1:0] bub_cnt_q, bub_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_load_q, mem_load_d;
    logic          mem_ind_q, mem_ind_d;
    logic          mem_phase_q, mem_phase_d;
    logic          hold_mem_q, hold_mem_d;
    logic          hold_ctrl_q, hold_ctrl_d;

    logic          en_fetch_q, en_fetch_d;
    logic          en_decode_q, en_decode_d;
    logic          en_execute_q, en_execute_d;
    logic          en_writeback_q, en_writeback_d;
    logic          en_update_pc_q, en_update_pc_d;
    logic          br_taken_q, br_taken_d;
    logic [1:0]    mem_state_q, mem_state_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic [3:0] op_exec, op_dec;
    logic       exec_is_load, exec_is_store, exec_is_mem, exec_is_ind, dec_is_ctrl;
    logic       mem_hit, ctrl_hit, cd_final, timeout_hit, br_cond;
    logic       unused_bits;

    assign op_exec       = ctrl_io.ir_exec[15:12];
    assign op_dec        = ctrl_io.instr_dout[15:12];
    assign exec_is_load  = (op_exec == OP_LD) || (op_exec == OP_LDR) || (op_exec == OP_LDI);
    assign exec_is_store = (op_exec == OP_ST) || (op_exec == OP_STR) || (op_exec == OP_STI);
    assign exec_is_mem   = exec_is_load || exec_is_store;
    assign exec_is_ind   = (op_exec == OP_LDI) || (op_exec == OP_STI);
    assign dec_is_ctrl   = (op_dec == OP_BR) || (op_dec == OP_JMP);
    assign unused_bits   = ^{ctrl_io.instr_dout[11:0], ctrl_io.ir_exec[8:0]};

    // The cycle right after a stall retires the stalled instruction, so it must not re-trigger.
    assign mem_hit     = (state_q == ST_RUN) && en_execute_q && !hold_mem_q && exec_is_mem;
    assign ctrl_hit    = (state_q == ST_RUN) && en_decode_q && !hold_ctrl_q && dec_is_ctrl;
    assign cd_final    = !(mem_ind_q && !mem_phase_q);
    assign timeout_hit = (state_q == ST_MEM) && !ctrl_io.complete_data && (wait_cnt_q == TO_LAST);
    assign br_cond     = (op_exec == OP_JMP) ||
                         ((op_exec == OP_BR) && (|(ctrl_io.ir_exec[11:9] & ctrl_io.psr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            fill_cnt_q     <= '0;
            bub_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            mem_load_q     <= 1'b0;
            mem_ind_q      <= 1'b0;
            mem_phase_q    <= 1'b0;
            hold_mem_q     <= 1'b0;
            hold_ctrl_q    <= 1'b0;
            en_fetch_q     <= 1'b0;
            en_decode_q    <= 1'b0;
            en_execute_q   <= 1'b0;
            en_writeback_q <= 1'b0;
            en_update_pc_q <= 1'b0;
            br_taken_q     <= 1'b0;
            mem_state_q    <= MS_IDLE;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            bub_cnt_q      <= bub_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_load_q     <= mem_load_d;
            mem_ind_q      <= mem_ind_d;
            mem_phase_q    <= mem_phase_d;
            hold_mem_q     <= hold_mem_d;
            hold_ctrl_q    <= hold_ctrl_d;
            en_fetch_q     <= en_fetch_d;
            en_decode_q    <= en_decode_d;
            en_execute_q   <= en_execute_d;
            en_writeback_q <= en_writeback_d;
            en_update_pc_q <= en_update_pc_d;
            br_taken_q     <= br_taken_d;
            mem_state_q    <= mem_state_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        bub_cnt_d   = bub_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_load_d  = mem_load_q;
        mem_ind_d   = mem_ind_q;
        mem_phase_d = mem_phase_q;
        hold_mem_d  = 1'b0;
        hold_ctrl_d = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + FW'(1);
                end
            end
            ST_RUN: begin
                if (mem_hit) begin
                    state_d     = ST_MEM;
                    mem_load_d  = exec_is_load;
                    mem_ind_d   = exec_is_ind;
                    mem_phase_d = 1'b0;
                    wait_cnt_d  = '0;
                end else if (ctrl_hit) begin
                    state_d   = ST_CTRL;
                    bub_cnt_d = '0;
                end
            end
            ST_MEM: begin
                if (ctrl_io.complete_data) begin
                    wait_cnt_d = '0;
                    if (cd_final) begin
                        state_d    = ST_RUN;
                        hold_mem_d = 1'b1;
                    end else begin
                        mem_phase_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_RUN;
                    hold_mem_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: begin
                if (bub_cnt_q == BUB_LAST) begin
                    state_d     = ST_RUN;
                    hold_ctrl_d = 1'b1;
                end else begin
                    bub_cnt_d = bub_cnt_q + BW'(1);
                end
            end
        endcase
    end

    always_comb begin
        en_fetch_d     = en_fetch_q;
        en_decode_d    = en_decode_q;
        en_execute_d   = en_execute_q;
        en_writeback_d = en_writeback_q;
        en_update_pc_d = en_update_pc_q;
        br_taken_d     = 1'b0;
        mem_state_d    = MS_IDLE;
        mem_timeout_d  = mem_timeout_q;
        case (state_q)
            ST_FILL: begin
                en_fetch_d     = 1'b1;
                en_update_pc_d = 1'b1;
                en_decode_d    = en_decode_q    || (fill_cnt_q >= FILL_DEC);
                en_execute_d   = en_execute_q   || (fill_cnt_q >= FILL_EXE);
                en_writeback_d = en_writeback_q || (fill_cnt_q >= FILL_WB);
                if (fill_cnt_q == FILL_LAST) begin
                    {en_fetch_d, en_decode_d, en_execute_d, en_writeback_d, en_update_pc_d} = '1;
                end
            end
            ST_RUN: begin
                {en_fetch_d, en_decode_d, en_execute_d, en_writeback_d, en_update_pc_d} = '1;
                if (mem_hit) begin
                    {en_fetch_d, en_decode_d, en_execute_d, en_update_pc_d} = '0;
                    en_writeback_d = exec_is_load;
                    mem_state_d    = exec_is_ind ? MS_IND : (exec_is_load ? MS_READ : MS_WRITE);
                end else if (ctrl_hit) begin
                    en_fetch_d     = 1'b0;
                    en_update_pc_d = 1'b0;
                end
            end
            ST_MEM: begin
                mem_state_d = mem_state_q;
                if (ctrl_io.complete_data) begin
                    if (cd_final) begin
                        {en_fetch_d, en_decode_d, en_execute_d, en_writeback_d, en_update_pc_d} = '1;
                        mem_state_d = MS_IDLE;
                    end else begin
                        mem_state_d = mem_load_q ? MS_READ : MS_WRITE;
                    end
                end else if (timeout_hit) begin
                    {en_fetch_d, en_decode_d, en_execute_d, en_writeback_d, en_update_pc_d} = '1;
                    mem_state_d   = MS_IDLE;
                    mem_timeout_d = 1'b1;
                end
            end
            default: begin
                if (bub_cnt_q == BUB_LAST) begin
                    en_fetch_d     = 1'b1;
                    en_update_pc_d = 1'b1;
                    br_taken_d     = br_cond;
                end
            end
        endcase
    end

    assign ctrl_io.enable_fetch     = en_fetch_q;
    assign ctrl_io.enable_decode    = en_decode_q;
    assign ctrl_io.enable_execute   = en_execute_q;
    assign ctrl_io.enable_writeback = en_writeback_q;
    assign ctrl_io.enable_update_pc = en_update_pc_q;
    assign ctrl_io.br_taken         = br_taken_q;
    assign ctrl_io.mem_state        = mem_state_q;
    assign ctrl_io.mem_timeout      = mem_timeout_q;
endmodule
